// File: rtl/serial_latch_pkg.sv
// Shared types and constants for the serial address latch.
//   mode_t     : write mode selected by the MODE input
//   hs_state_t : output handshake state (EMPTY / FULL)
package serial_latch_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    MODE_ADDR   = 1'b0,
    MODE_SERIAL = 1'b1
  } mode_t;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } hs_state_t;

endpackage

// File: rtl/sel_counter.sv
// Wrapping select counter used to deserialise a bit stream LSB-first.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_clr    : synchronous clear (wins over i_en)
//   i_en     : count enable
//   o_count  : current count
//   o_tc     : terminal count, high when the count is at its maximum and enabled
module sel_counter #(
  parameter int unsigned SEL_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [SEL_W-1:0] o_count,
  output logic             o_tc
);

  logic [SEL_W-1:0] r_count;
  logic [SEL_W-1:0] w_count_nxt;

  always_comb begin
    w_count_nxt = r_count;
    if (i_clr) begin
      w_count_nxt = '0;
    end else if (i_en) begin
      w_count_nxt = r_count + 1'b1;  // natural wrap at 2**SEL_W
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign o_count = r_count;
  assign o_tc    = i_en && !i_clr && (r_count == {SEL_W{1'b1}});

endmodule

// File: rtl/serial_addr_latch.sv
// Addressed / auto-serial bit latch with a VALID/READY word output.
// Addressed mode writes D to Q[S]; serial mode writes D to Q[IDX] and advances
// IDX, handing out each completed word through a one-entry output register.
// Ports:
//   CLK    : clock, rising edge
//   N_RST  : asynchronous active-low reset
//   N_E    : write enable, active-low
//   N_CLR  : synchronous clear, active-low (clears Q, IDX, OVF; keeps WORD/VALID)
//   MODE   : 0 addressed, 1 auto-serial
//   S      : write address (addressed mode only)
//   D      : data bit
//   READY  : consumer accepts WORD
//   Q      : live latch contents
//   IDX    : current serial bit index
//   WORD   : last completed serial word
//   VALID  : WORD holds an unconsumed word
//   OVF    : sticky, a completed word was dropped
module serial_addr_latch
  import serial_latch_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                       CLK,
  input  logic                       N_RST,
  input  logic                       N_E,
  input  logic                       N_CLR,
  input  logic                       MODE,
  input  logic [$clog2(WIDTH)-1:0]   S,
  input  logic                       D,
  input  logic                       READY,
  output logic [WIDTH-1:0]           Q,
  output logic [$clog2(WIDTH)-1:0]   IDX,
  output logic [WIDTH-1:0]           WORD,
  output logic                       VALID,
  output logic                       OVF
);

  localparam int unsigned SEL_W = $clog2(WIDTH);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("serial_addr_latch: WIDTH must be a power of two and at least 2");
  end

  mode_t            w_mode;
  logic             w_clr;
  logic             w_wr;
  logic             w_ser_wr;
  logic [SEL_W-1:0] w_idx;
  logic [SEL_W-1:0] w_wr_idx;
  logic             w_done;
  logic [WIDTH-1:0] w_done_word;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] w_word_nxt;
  hs_state_t        r_state;
  hs_state_t        w_state_nxt;
  logic             r_ovf;
  logic             w_ovf_set;

  assign w_mode   = mode_t'(MODE);
  assign w_clr    = !N_CLR;
  // Clear wins over any write in the same cycle.
  assign w_wr     = !N_E && N_CLR;
  assign w_ser_wr = w_wr && (w_mode == MODE_SERIAL);
  assign w_wr_idx = (w_mode == MODE_SERIAL) ? w_idx : S;

  sel_counter #(
    .SEL_W (SEL_W)
  ) u_sel_counter (
    .i_clk   (CLK),
    .i_rst_n (N_RST),
    .i_clr   (w_clr),
    .i_en    (w_ser_wr),
    .o_count (w_idx),
    .o_tc    (w_done)
  );

  // The last bit arrives on the completing edge, so splice D in directly.
  assign w_done_word = {D, r_q[WIDTH-2:0]};

  always_comb begin
    w_q_nxt = r_q;
    if (w_clr) begin
      w_q_nxt = '0;
    end else if (w_wr) begin
      w_q_nxt[w_wr_idx] = D;
    end
  end

  // Handshake: completion has priority over a plain transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_ovf_set   = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_done) begin
          w_word_nxt  = w_done_word;
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_done) begin
          if (READY) begin
            w_word_nxt = w_done_word;
          end else begin
            w_ovf_set = 1'b1;
          end
        end else if (READY) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      r_q     <= '0;
      r_word  <= '0;
      r_state <= ST_EMPTY;
      r_ovf   <= 1'b0;
    end else begin
      r_q     <= w_q_nxt;
      r_word  <= w_word_nxt;
      r_state <= w_state_nxt;
      if (w_clr) begin
        r_ovf <= 1'b0;
      end else if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign Q     = r_q;
  assign IDX   = w_idx;
  assign WORD  = r_word;
  assign VALID = (r_state == ST_FULL);
  assign OVF   = r_ovf;

`ifdef FORMAL
  a_valid_fall : assert property (@(posedge CLK) disable iff (!N_RST)
    $fell(VALID) |-> $past(VALID && READY));
  a_ovf_rise : assert property (@(posedge CLK) disable iff (!N_RST)
    $rose(OVF) |-> $past(VALID && !READY && w_done));
  a_word_stable_full : assert property (@(posedge CLK) disable iff (!N_RST)
    ($past(VALID) && !$past(READY)) |-> $stable(WORD));
`endif

endmodule

// File: tb/tb_serial_addr_latch.sv
// Self-checking bench for serial_addr_latch: directed scenarios plus random
// stimulus checked against a behavioural model of the latch and handshake.
module tb_serial_addr_latch;

  localparam int W = 8;

  logic         CLK;
  logic         N_RST;
  logic         N_E;
  logic         N_CLR;
  logic         MODE;
  logic [2:0]   S;
  logic         D;
  logic         READY;
  logic [W-1:0] Q;
  logic [2:0]   IDX;
  logic [W-1:0] WORD;
  logic         VALID;
  logic         OVF;

  int n_cmp;
  int n_fail;

  // Behavioural model state.
  logic [W-1:0] m_q;
  int           m_idx;
  logic [W-1:0] m_word;
  bit           m_valid;
  bit           m_ovf;

  serial_addr_latch #(
    .WIDTH (W)
  ) dut (
    .CLK   (CLK),
    .N_RST (N_RST),
    .N_E   (N_E),
    .N_CLR (N_CLR),
    .MODE  (MODE),
    .S     (S),
    .D     (D),
    .READY (READY),
    .Q     (Q),
    .IDX   (IDX),
    .WORD  (WORD),
    .VALID (VALID),
    .OVF   (OVF)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic model_reset();
    m_q     = '0;
    m_idx   = 0;
    m_word  = '0;
    m_valid = 0;
    m_ovf   = 0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, sample 1 time unit later.
  task automatic cycle(input bit ne, input bit nclr, input bit mode, input int s,
                       input bit d, input bit rdy);
    logic [W-1:0] nw;
    bit           done;
    N_E = ne; N_CLR = nclr; MODE = mode; S = 3'(s); D = d; READY = rdy;
    @(posedge CLK);
    done = 0;
    nw   = m_q;
    if (!nclr) begin
      m_q   = '0;
      m_idx = 0;
      m_ovf = 0;
    end else if (!ne) begin
      if (mode) begin
        m_q[m_idx] = d;
        done       = (m_idx == W - 1);
        nw         = m_q;
        m_idx      = (m_idx + 1) % W;
      end else begin
        m_q[s] = d;
      end
    end
    if (done) begin
      if (!m_valid) begin
        m_word  = nw;
        m_valid = 1;
      end else if (rdy) begin
        m_word = nw;
      end else begin
        m_ovf = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic idle(input bit rdy);
    cycle(1, 1, 1, 0, 0, rdy);
  endtask

  // Stream a word LSB-first; READY is rdy_mid on bits 0..6 and rdy_last on bit 7.
  task automatic stream_word(input logic [W-1:0] w, input bit rdy_mid, input bit rdy_last);
    for (int i = 0; i < W; i++) begin
      cycle(0, 1, 1, 0, w[i], (i == W - 1) ? rdy_last : rdy_mid);
    end
  endtask

  task automatic test_reset();
    N_RST = 1'b0;
    N_E = 1; N_CLR = 1; MODE = 0; S = 0; D = 0; READY = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #2 N_RST = 1'b1;
    @(posedge CLK); #1;
    n_cmp++;
    if (Q !== '0 || IDX !== '0 || WORD !== '0 || VALID !== 1'b0 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: got Q=%h IDX=%0d WORD=%h VALID=%b OVF=%b want all 0",
               Q, IDX, WORD, VALID, OVF);
    end
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 1, 0);
    for (int i = 3; i < W; i++) cycle(0, 1, 0, i, 1, 0);
    n_cmp++;
    if (Q !== 8'hFF || IDX !== 3'd3) begin
      n_fail++;
      $display("FAIL reset_preload: got Q=%h IDX=%0d want Q=ff IDX=3", Q, IDX);
    end
    #3 N_RST = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (Q !== '0 || IDX !== '0 || WORD !== '0 || VALID !== 1'b0 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got Q=%h IDX=%0d WORD=%h VALID=%b OVF=%b want all 0",
               Q, IDX, WORD, VALID, OVF);
    end
    #2 N_RST = 1'b1;
    idle(0);
  endtask

  task automatic test_addressed();
    logic [W-1:0] exp_q [3];
    int           addr  [3];
    bit           dat   [3];
    exp_q[0] = 8'h08; exp_q[1] = 8'h48; exp_q[2] = 8'h40;
    addr[0]  = 3;     addr[1]  = 6;     addr[2]  = 3;
    dat[0]   = 1;     dat[1]   = 1;     dat[2]   = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, addr[i], dat[i], 0);
      n_cmp++;
      if (Q !== exp_q[i] || IDX !== 3'd0 || VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL addr_write%0d: got Q=%h IDX=%0d VALID=%b want Q=%h IDX=0 VALID=0",
                 i, Q, IDX, VALID, exp_q[i]);
      end
    end
  endtask

  task automatic test_serial();
    cycle(1, 0, 1, 0, 0, 0);
    stream_word(8'h4D, 0, 0);
    n_cmp++;
    if (WORD !== 8'h4D || VALID !== 1'b1 || IDX !== 3'd0) begin
      n_fail++;
      $display("FAIL serial_done: got WORD=%h VALID=%b IDX=%0d want WORD=4d VALID=1 IDX=0",
               WORD, VALID, IDX);
    end
    idle(1);
    n_cmp++;
    if (VALID !== 1'b0 || WORD !== 8'h4D) begin
      n_fail++;
      $display("FAIL serial_take: got VALID=%b WORD=%h want VALID=0 WORD=4d", VALID, WORD);
    end
  endtask

  task automatic test_overflow();
    stream_word(8'h4D, 0, 0);
    stream_word(8'hA5, 0, 0);
    n_cmp++;
    if (WORD !== 8'h4D || OVF !== 1'b1 || VALID !== 1'b1 || Q !== 8'hA5) begin
      n_fail++;
      $display("FAIL ovf_drop: got WORD=%h OVF=%b VALID=%b Q=%h want 4d 1 1 a5",
               WORD, OVF, VALID, Q);
    end
    cycle(1, 0, 1, 0, 0, 0);
    n_cmp++;
    if (OVF !== 1'b0 || IDX !== 3'd0 || Q !== '0 || VALID !== 1'b1 || WORD !== 8'h4D) begin
      n_fail++;
      $display("FAIL ovf_clr: got OVF=%b IDX=%0d Q=%h VALID=%b WORD=%h want 0 0 00 1 4d",
               OVF, IDX, Q, VALID, WORD);
    end
  endtask

  task automatic test_back_to_back();
    idle(1);
    stream_word(8'h01, 0, 0);
    n_cmp++;
    if (WORD !== 8'h01 || VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: got WORD=%h VALID=%b want 01 1", WORD, VALID);
    end
    for (int i = 0; i < W; i++) begin
      cycle(0, 1, 1, 0, (i == W - 1), (i == W - 1));
      n_cmp++;
      if (VALID !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_valid bit%0d: got VALID=%b want 1", i, VALID);
      end
    end
    n_cmp++;
    if (WORD !== 8'h80 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: got WORD=%h OVF=%b want 80 0", WORD, OVF);
    end
    idle(1);
    n_cmp++;
    if (VALID !== 1'b0 || WORD !== 8'h80) begin
      n_fail++;
      $display("FAIL b2b_drain: got VALID=%b WORD=%h want 0 80", VALID, WORD);
    end
  endtask

  task automatic test_enable_gating();
    logic [W-1:0] w;
    logic [W-1:0] q_hold;
    w = 8'($urandom);
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, w[i], 0);
    q_hold = m_q;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 1, $urandom_range(0, 7), 1'($urandom), 0);
      n_cmp++;
      if (IDX !== 3'd4 || Q !== q_hold) begin
        n_fail++;
        $display("FAIL gate_hold%0d: got IDX=%0d Q=%h want IDX=4 Q=%h", i, IDX, Q, q_hold);
      end
    end
    for (int i = 4; i < W; i++) cycle(0, 1, 1, 0, w[i], 0);
    n_cmp++;
    if (WORD !== w || VALID !== 1'b1 || IDX !== 3'd0) begin
      n_fail++;
      $display("FAIL gate_word: got WORD=%h VALID=%b IDX=%0d want %h 1 0", WORD, VALID, IDX, w);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 19) != 0),
            ($urandom_range(0, 9) < 7), $urandom_range(0, 7), 1'($urandom),
            ($urandom_range(0, 2) == 0));
      n_cmp++;
      if (Q !== m_q || IDX !== 3'(m_idx) || WORD !== m_word || VALID !== m_valid ||
          OVF !== m_ovf) begin
        n_fail++;
        $display("FAIL random%0d: got Q=%h IDX=%0d WORD=%h VALID=%b OVF=%b want %h %0d %h %b %b",
                 n, Q, IDX, WORD, VALID, OVF, m_q, m_idx, m_word, m_valid, m_ovf);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_addressed();
    test_serial();
    test_overflow();
    test_back_to_back();
    test_enable_gating();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
